mac_accum_stage: RTL and testbench



---
 rtl/mac_accum_stage_pkg.sv | 25 ++
 rtl/mac_accum_stage_fxp_mul.sv | 51 +++++
 rtl/mac_accum_stage.sv | 139 +++++++++++++
 tb/tb_mac_accum_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mac_accum_stage_pkg.sv
// rtl/mac_accum_stage_pkg.sv - shared PE widths and signed-saturate helper for the MAC accumulate stage
package mac_accum_stage_pkg;

  localparam int PE_DATA_WIDTH     = 16;
  localparam int PE_FRAC_BITS      = 8;
  localparam int PE_ACT_NUM        = 64;
  localparam int PE_ACT_ADDR_WIDTH = 6;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  // The caller narrows the result to w bits afterwards.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/mac_accum_stage_fxp_mul.sv
// rtl/mac_accum_stage_fxp_mul.sv - registered fixed-point multiply (stage S1), clamps when ACC_SATURATE_EN is defined
module fxp_mul
  import mac_accum_stage_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int FRAC_BITS  = PE_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] prod
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]   a_ext;
  logic signed [PW-1:0]   b_ext;
  logic signed [PW-1:0]   full;
  logic signed [PW-1:0]   shifted;
  logic [DATA_WIDTH-1:0]  narrow;

  // Full-precision product, rescale by the fraction bits, then narrow to the word width
  always_comb begin
    a_ext   = PW'($signed(a));
    b_ext   = PW'($signed(b));
    full    = a_ext * b_ext;
    shifted = full >>> FRAC_BITS;
`ifdef ACC_SATURATE_EN
    narrow  = DATA_WIDTH'(sat_clamp(64'(shifted), DATA_WIDTH));
`else
    narrow  = DATA_WIDTH'(shifted);
`endif
  end

  // S1 register: valid always follows, data only loads on a live op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      prod      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        prod <= narrow;
      end
    end
  end

endmodule

// File: rtl/mac_accum_stage.sv
// rtl/mac_accum_stage.sv - MAC accumulate stage top; ACC_SATURATE_EN selects clamping instead of wrap
module mac_accum_stage
  import mac_accum_stage_pkg::*;
#(
  parameter int PE_IDX         = 0,
  parameter int DATA_WIDTH     = PE_DATA_WIDTH,
  parameter int FRAC_BITS      = PE_FRAC_BITS,
  parameter int ACT_NUM        = PE_ACT_NUM,
  parameter int ACT_ADDR_WIDTH = PE_ACT_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      comp_en_mem,
  input  logic [DATA_WIDTH-1:0]     in_act_value_mem,
  input  logic [ACT_ADDR_WIDTH-1:0] out_act_addr_mem,
  input  logic [DATA_WIDTH-1:0]     w_mem_q,
  input  logic                      acc_clr,
  input  logic                      rd_en,
  input  logic [ACT_ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      busy
);

  localparam int SW = DATA_WIDTH + 1;

  // The address width must index the whole file exactly; PE_IDX is only a tag
  if (PE_IDX < 0 || ACT_NUM != (1 << ACT_ADDR_WIDTH)) begin : g_bad_cfg
    $error("mac_accum_stage: inconsistent ACT_NUM/ACT_ADDR_WIDTH or PE_IDX");
  end

  logic                      valid_s0;
  logic [DATA_WIDTH-1:0]     value_s0;
  logic [ACT_ADDR_WIDTH-1:0] addr_s0;

  logic                      valid_s1;
  logic [DATA_WIDTH-1:0]     prod_s1;
  logic [ACT_ADDR_WIDTH-1:0] addr_s1;

  logic                      valid_s2;
  logic [DATA_WIDTH-1:0]     sum_s2;
  logic [ACT_ADDR_WIDTH-1:0] addr_s2;

  logic [DATA_WIDTH-1:0]     operand;
  logic signed [SW-1:0]      sum_full;
  logic [DATA_WIDTH-1:0]     sum_next;

  logic [DATA_WIDTH-1:0]     acc [ACT_NUM];

  // S0: hold the activation and index one cycle so they meet the weight read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_s0 <= 1'b0;
      value_s0 <= '0;
      addr_s0  <= '0;
    end else begin
      valid_s0 <= comp_en_mem;
      if (comp_en_mem) begin
        value_s0 <= in_act_value_mem;
        addr_s0  <= out_act_addr_mem;
      end
    end
  end

  fxp_mul #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_fxp_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (valid_s0),
    .a         (value_s0),
    .b         (w_mem_q),
    .out_valid (valid_s1),
    .prod      (prod_s1)
  );

  // S1 address travels alongside the product register inside fxp_mul
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_s1 <= '0;
    end else if (valid_s0) begin
      addr_s1 <= addr_s0;
    end
  end

  // S2 operand: forward the pending sum when it targets the same entry, since it is not yet written
  always_comb begin
    operand  = (valid_s2 && (addr_s2 == addr_s1)) ? sum_s2 : acc[addr_s1];
    sum_full = SW'($signed(operand)) + SW'($signed(prod_s1));
`ifdef ACC_SATURATE_EN
    sum_next = DATA_WIDTH'(sat_clamp(64'(sum_full), DATA_WIDTH));
`else
    sum_next = DATA_WIDTH'(sum_full);
`endif
  end

  // S2 register: the sum waits here one cycle before write-back and doubles as the forward source
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_s2 <= 1'b0;
      addr_s2  <= '0;
      sum_s2   <= '0;
    end else begin
      valid_s2 <= valid_s1;
      if (valid_s1) begin
        addr_s2 <= addr_s1;
        sum_s2  <= sum_next;
      end
    end
  end

  // Accumulator file: clear beats a same-edge write-back, so that op is dropped
  always_ff @(posedge clk) begin
    if (!rst_n || acc_clr) begin
      for (int i = 0; i < ACT_NUM; i++) begin
        acc[i] <= '0;
      end
    end else if (valid_s2) begin
      acc[addr_s2] <= sum_s2;
    end
  end

  // Readout register: samples the pre-edge contents, so same-edge writes and clears are not seen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= acc[rd_addr];
      end
    end
  end

  assign busy = valid_s0 | valid_s1 | valid_s2;

endmodule

// File: tb/tb_mac_accum_stage.sv
// tb/tb_mac_accum_stage.sv - directed self-checking bench for mac_accum_stage (honours ACC_SATURATE_EN)
module tb_mac_accum_stage;

  logic        clk;
  logic        rst_n;
  logic        comp_en_mem;
  logic [15:0] in_act_value_mem;
  logic [5:0]  out_act_addr_mem;
  logic [15:0] w_mem_q;
  logic        acc_clr;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] op_val  [16];
  logic [15:0] op_w    [16];
  logic [5:0]  op_addr [16];

  mac_accum_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .comp_en_mem      (comp_en_mem),
    .in_act_value_mem (in_act_value_mem),
    .out_act_addr_mem (out_act_addr_mem),
    .w_mem_q          (w_mem_q),
    .acc_clr          (acc_clr),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [5:0] a, input logic [15:0] v, input logic [15:0] w);
    op_addr[i] = a;
    op_val[i]  = v;
    op_w[i]    = w;
  endtask

  // Issue n ops back to back; the weight for op i arrives one cycle after its comp_en_mem
  task automatic run_ops(input int n);
    for (int i = 0; i <= n; i++) begin
      comp_en_mem = (i < n);
      if (i < n) begin
        in_act_value_mem = op_val[i];
        out_act_addr_mem = op_addr[i];
      end
      w_mem_q = (i > 0) ? op_w[i-1] : 16'h0;
      step();
    end
    comp_en_mem = 1'b0;
    w_mem_q     = 16'h0;
    repeat (4) step();
  endtask

  task automatic read_check(input logic [5:0] a, input logic [15:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check_eq(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; comp_en_mem = 1'b0; in_act_value_mem = '0; out_act_addr_mem = '0;
    w_mem_q = '0; acc_clr = 1'b0; rd_en = 1'b0; rd_addr = '0;

    // Reset state and full readout of zeros
    repeat (2) step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 64; a++) begin
      read_check(6'(a), 16'h0000, $sformatf("rst_acc%0d", a));
    end
    step();
    check_eq("rd_valid_drop", 32'(rd_valid), 32'd0);

    // Single op: 1.5 * 2.0 at addr 5, busy window T+1..T+3, readout in T+4
    comp_en_mem = 1'b1; in_act_value_mem = 16'h0180; out_act_addr_mem = 6'd5;
    step();
    comp_en_mem = 1'b0; w_mem_q = 16'h0200;
    check_eq("single_busy_t1", 32'(busy), 32'd1);
    step();
    w_mem_q = 16'h0;
    check_eq("single_busy_t2", 32'(busy), 32'd1);
    step();
    check_eq("single_busy_t3", 32'(busy), 32'd1);
    step();
    check_eq("single_busy_t4", 32'(busy), 32'd0);
    read_check(6'd5, 16'h0300, "single_acc5");
    step();
    check_eq("rd_hold_valid", 32'(rd_valid), 32'd0);
    check_eq("rd_hold_data", 32'(rd_data), 32'h0300);

    // Forwarding: four back-to-back ops on one entry
    for (int i = 0; i < 4; i++) set_op(i, 6'd7, 16'h0100, 16'h0100);
    run_ops(4);
    read_check(6'd7, 16'h0400, "fwd_acc7_a");
    // Alternating entries: ops on the same entry two cycles apart
    for (int i = 0; i < 4; i++) set_op(i, (i % 2 == 0) ? 6'd7 : 6'd8, 16'h0100, 16'h0100);
    run_ops(4);
    read_check(6'd7, 16'h0600, "alt_acc7");
    read_check(6'd8, 16'h0200, "alt_acc8");

    // Overflow of the accumulator and of product narrowing
    for (int i = 0; i < 3; i++) set_op(i, 6'd2, 16'h7F00, 16'h0100);
    set_op(3, 6'd3, 16'h7F00, 16'h7F00);
    set_op(4, 6'd4, 16'hFF00, 16'h0200);
    set_op(5, 6'd6, 16'h8100, 16'h7F00);
    run_ops(6);
`ifdef ACC_SATURATE_EN
    read_check(6'd2, 16'h7FFF, "ovf_acc2");
    read_check(6'd3, 16'h7FFF, "ovf_prod_pos");
    read_check(6'd6, 16'h8000, "ovf_prod_neg");
`else
    read_check(6'd2, 16'h7D00, "ovf_acc2");
    read_check(6'd3, 16'h0100, "ovf_prod_pos");
    read_check(6'd6, 16'hFF00, "ovf_prod_neg");
`endif
    read_check(6'd4, 16'hFE00, "neg_prod");

    // Clear on the write-back edge of a second op to addr 5; same-edge readout sees old 0x0300
    comp_en_mem = 1'b1; in_act_value_mem = 16'h0180; out_act_addr_mem = 6'd5;
    step();
    comp_en_mem = 1'b0; w_mem_q = 16'h0200;
    step();
    w_mem_q = 16'h0;
    step();
    acc_clr = 1'b1; rd_en = 1'b1; rd_addr = 6'd5;
    step();
    acc_clr = 1'b0; rd_en = 1'b0;
    check_eq("clr_same_edge_rd", 32'(rd_data), 32'h0300);
    check_eq("clr_busy", 32'(busy), 32'd0);
    step();
    read_check(6'd5, 16'h0000, "clr_acc5");
    read_check(6'd7, 16'h0000, "clr_acc7");

    // Mid-op reset with three ops in flight
    for (int i = 0; i < 3; i++) set_op(i, 6'd9, 16'h0100, 16'h0100);
    read_check(6'd9, 16'h0000, "pre_acc9");
    set_op(3, 6'd10, 16'h0100, 16'h0100);
    run_ops(4);
    read_check(6'd10, 16'h0100, "pre_rst_acc10");
    for (int i = 0; i < 3; i++) begin
      comp_en_mem = 1'b1; in_act_value_mem = 16'h0100; out_act_addr_mem = 6'd9;
      w_mem_q = (i > 0) ? 16'h0100 : 16'h0;
      step();
    end
    check_eq("inflight_busy", 32'(busy), 32'd1);
    comp_en_mem = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    w_mem_q = 16'h0;
    repeat (4) step();
    check_eq("midrst_busy_late", 32'(busy), 32'd0);
    read_check(6'd9, 16'h0000, "midrst_acc9");
    read_check(6'd10, 16'h0000, "midrst_acc10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
